// File: rtl/ami_w.sv
// ami_w: AXI4 master write engine.
// Takes one user write-burst command at a time, drives AW, streams user beats
// onto W with an internally generated WLAST, and returns B as one-cycle pulses.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   AW*/W*/B*                  AXI4 write address, data and response channels
//   usr_cmd_*                  burst command in (valid/ready), err pulse out
//   usr_w*                     user write data in (valid/ready)
//   usr_b*                     write response pulse out
module ami_w #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 32,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_BRESPW = 2,
    parameter int OST        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [AXI_IW-1:0]       AWID,
    output logic [AXI_AW-1:0]       AWADDR,
    output logic [AXI_LW-1:0]       AWLEN,
    output logic [AXI_SW-1:0]       AWSIZE,
    output logic [1:0]              AWBURST,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [AXI_DW-1:0]       WDATA,
    output logic [AXI_DW/8-1:0]     WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [AXI_IW-1:0]       BID,
    input  logic [AXI_BRESPW-1:0]   BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    input  logic                    usr_cmd_valid,
    output logic                    usr_cmd_ready,
    input  logic [AXI_IW-1:0]       usr_cmd_id,
    input  logic [AXI_AW-1:0]       usr_cmd_addr,
    input  logic [AXI_LW-1:0]       usr_cmd_len,
    input  logic [AXI_SW-1:0]       usr_cmd_size,
    input  logic [1:0]              usr_cmd_burst,
    output logic                    usr_cmd_err,
    input  logic [AXI_DW-1:0]       usr_wdata,
    input  logic [AXI_DW/8-1:0]     usr_wstrb,
    input  logic                    usr_wvalid,
    output logic                    usr_wready,
    output logic                    usr_bvalid,
    output logic [AXI_IW-1:0]       usr_bid,
    output logic [AXI_BRESPW-1:0]   usr_bresp
);

    localparam int OCW   = $clog2(OST + 1);
    localparam int MAXSZ = $clog2(AXI_DW / 8);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        WAIT_AW = 2'd2
    } state_e;

    state_e                  st_q, st_d;
    logic                    awvalid_q, awvalid_d;
    logic                    aw_done_q, aw_done_d;
    logic [AXI_LW-1:0]       beat_q, beat_d;
    logic [AXI_IW-1:0]       awid_q, awid_d;
    logic [AXI_AW-1:0]       awaddr_q, awaddr_d;
    logic [AXI_LW-1:0]       awlen_q, awlen_d;
    logic [AXI_SW-1:0]       awsize_q, awsize_d;
    logic [1:0]              awburst_q, awburst_d;
    logic                    err_q, err_d;
    logic [OCW-1:0]          ost_cnt_q, ost_cnt_d;
    logic                    bvalid_q, bvalid_d;
    logic [AXI_IW-1:0]       bid_q, bid_d;
    logic [AXI_BRESPW-1:0]   bresp_q, bresp_d;

    logic                    cmd_acc;
    logic                    cmd_ok;
    logic                    size_bad;
    logic                    wrap_bad;
    logic                    cross_4k;
    logic [AXI_AW:0]         aligned;
    logic [AXI_AW:0]         span;
    logic [AXI_AW:0]         last_addr;
    logic                    in_burst;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    legal_acc;

    // Command legality, evaluated on the raw command in the accept cycle.
    always_comb begin
        aligned   = {1'b0, usr_cmd_addr
                    & ~((AXI_AW'(1) << usr_cmd_size) - AXI_AW'(1))};
        span      = ((AXI_AW+1)'(usr_cmd_len) + (AXI_AW+1)'(1))
                    << usr_cmd_size;
        last_addr = aligned + span - (AXI_AW+1)'(1);
        size_bad  = 32'(usr_cmd_size) > 32'(MAXSZ);
        wrap_bad  = (usr_cmd_burst == 2'd2)
                    && !(usr_cmd_len == AXI_LW'(1)
                      || usr_cmd_len == AXI_LW'(3)
                      || usr_cmd_len == AXI_LW'(7)
                      || usr_cmd_len == AXI_LW'(15));
        cross_4k  = (usr_cmd_burst == 2'd1)
                    && (last_addr[AXI_AW-1:12] != usr_cmd_addr[AXI_AW-1:12]);
        cmd_ok    = !size_bad && !wrap_bad && !cross_4k
                    && (usr_cmd_burst != 2'd3);
    end

    assign usr_cmd_ready = (st_q == IDLE) && (ost_cnt_q < OCW'(OST));
    assign cmd_acc       = usr_cmd_valid && usr_cmd_ready;
    assign legal_acc     = cmd_acc && cmd_ok;

    assign in_burst   = (st_q == BURST);
    assign WVALID     = in_burst && usr_wvalid;
    assign usr_wready = in_burst && WREADY;
    assign WLAST      = in_burst && (beat_q == awlen_q);
    assign WDATA      = usr_wdata;
    assign WSTRB      = usr_wstrb;
    assign BREADY     = 1'b1;

    assign aw_hs = awvalid_q && AWREADY;
    assign w_hs  = WVALID && WREADY;

    always_comb begin
        st_d      = st_q;
        awvalid_d = awvalid_q;
        aw_done_d = aw_done_q;
        beat_d    = beat_q;
        awid_d    = awid_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        err_d     = 1'b0;

        if (aw_hs) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
        end

        unique case (st_q)
            IDLE: begin
                if (cmd_acc) begin
                    if (cmd_ok) begin
                        awid_d    = usr_cmd_id;
                        awaddr_d  = usr_cmd_addr;
                        awlen_d   = usr_cmd_len;
                        awsize_d  = usr_cmd_size;
                        awburst_d = usr_cmd_burst;
                        awvalid_d = 1'b1;
                        aw_done_d = 1'b0;
                        beat_d    = '0;
                        st_d      = BURST;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BURST: begin
                if (w_hs) begin
                    beat_d = beat_q + AXI_LW'(1);
                    if (beat_q == awlen_q) begin
                        // AW may complete in this very cycle.
                        st_d = (aw_done_q || aw_hs) ? IDLE : WAIT_AW;
                    end
                end
            end
            WAIT_AW: begin
                if (aw_hs) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    // Outstanding count; a response with nothing tracked leaves it at zero.
    always_comb begin
        ost_cnt_d = ost_cnt_q;
        if (legal_acc && !BVALID) begin
            ost_cnt_d = ost_cnt_q + OCW'(1);
        end else if (!legal_acc && BVALID && ost_cnt_q != '0) begin
            ost_cnt_d = ost_cnt_q - OCW'(1);
        end
    end

    always_comb begin
        bvalid_d = BVALID;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        if (BVALID) begin
            bid_d   = BID;
            bresp_d = BRESP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= IDLE;
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b0;
            beat_q    <= '0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            err_q     <= 1'b0;
            ost_cnt_q <= '0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            st_q      <= st_d;
            awvalid_q <= awvalid_d;
            aw_done_q <= aw_done_d;
            beat_q    <= beat_d;
            awid_q    <= awid_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            err_q     <= err_d;
            ost_cnt_q <= ost_cnt_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign AWID        = awid_q;
    assign AWADDR      = awaddr_q;
    assign AWLEN       = awlen_q;
    assign AWSIZE      = awsize_q;
    assign AWBURST     = awburst_q;
    assign AWVALID     = awvalid_q;
    assign usr_cmd_err = err_q;
    assign usr_bvalid  = bvalid_q;
    assign usr_bid     = bid_q;
    assign usr_bresp   = bresp_q;

endmodule

// File: tb/tb_ami_w.sv
// tb_ami_w: directed bench for ami_w.
// Inputs driven 1ns after posedge, outputs checked on negedge.
module tb_ami_w;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    AWID;
  logic [31:0]   AWADDR;
  logic [7:0]    AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST;
  logic          AWVALID;
  logic          AWREADY;
  logic [127:0]  WDATA;
  logic [15:0]   WSTRB;
  logic          WLAST;
  logic          WVALID;
  logic          WREADY;
  logic [7:0]    BID;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic          usr_cmd_valid;
  logic          usr_cmd_ready;
  logic [7:0]    usr_cmd_id;
  logic [31:0]   usr_cmd_addr;
  logic [7:0]    usr_cmd_len;
  logic [2:0]    usr_cmd_size;
  logic [1:0]    usr_cmd_burst;
  logic          usr_cmd_err;
  logic [127:0]  usr_wdata;
  logic [15:0]   usr_wstrb;
  logic          usr_wvalid;
  logic          usr_wready;
  logic          usr_bvalid;
  logic [7:0]    usr_bid;
  logic [1:0]    usr_bresp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ami_w dut (
    .clk(clk), .rst_n(rst_n),
    .AWID(AWID), .AWADDR(AWADDR),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB),
    .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY), .BID(BID),
    .BRESP(BRESP), .BVALID(BVALID),
    .BREADY(BREADY),
    .usr_cmd_valid(usr_cmd_valid),
    .usr_cmd_ready(usr_cmd_ready),
    .usr_cmd_id(usr_cmd_id),
    .usr_cmd_addr(usr_cmd_addr),
    .usr_cmd_len(usr_cmd_len),
    .usr_cmd_size(usr_cmd_size),
    .usr_cmd_burst(usr_cmd_burst),
    .usr_cmd_err(usr_cmd_err),
    .usr_wdata(usr_wdata),
    .usr_wstrb(usr_wstrb),
    .usr_wvalid(usr_wvalid),
    .usr_wready(usr_wready),
    .usr_bvalid(usr_bvalid),
    .usr_bid(usr_bid),
    .usr_bresp(usr_bresp)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] id,
                       input logic [31:0] addr,
                       input logic [7:0] len,
                       input logic [2:0] size,
                       input logic [1:0] burst);
    usr_cmd_valid = 1'b1;
    usr_cmd_id    = id;
    usr_cmd_addr  = addr;
    usr_cmd_len   = len;
    usr_cmd_size  = size;
    usr_cmd_burst = burst;
    @(negedge clk);
    chk("cmd_ready_at_issue", usr_cmd_ready, 1'b1);
    nxt();
    usr_cmd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] id,
                        input logic [1:0] resp);
    BVALID = 1'b1;
    BID    = id;
    BRESP  = resp;
    nxt();
    BVALID = 1'b0;
    @(negedge clk);
    chk("usr_bvalid_pulse", usr_bvalid, 1'b1);
    chk("usr_bid", usr_bid, id);
    chk("usr_bresp", usr_bresp, resp);
    nxt();
    @(negedge clk);
    chk("usr_bvalid_drop", usr_bvalid, 1'b0);
    nxt();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (usr_cmd_ready) break;
      nxt();
    end
    chk("idle_reached", usr_cmd_ready, 1'b1);
    nxt();
  endtask

  task automatic chk_err();
    @(negedge clk);
    chk("err_pulse", usr_cmd_err, 1'b1);
    chk("err_no_awvalid", AWVALID, 1'b0);
    chk("err_ready", usr_cmd_ready, 1'b1);
    nxt();
    @(negedge clk);
    chk("err_drop", usr_cmd_err, 1'b0);
    chk("err_no_awvalid2", AWVALID, 1'b0);
    nxt();
  endtask

  initial begin
    int cnt;
    int cyc;
    rst_n = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0;
    BVALID = 1'b0; BID = '0; BRESP = '0;
    usr_cmd_valid = 1'b0; usr_cmd_id = '0;
    usr_cmd_addr = '0; usr_cmd_len = '0;
    usr_cmd_size = '0; usr_cmd_burst = '0;
    usr_wdata = '0; usr_wstrb = '1;
    usr_wvalid = 1'b0;
    repeat (2) nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_awvalid", AWVALID, 1'b0);
    chk("rst_wvalid", WVALID, 1'b0);
    chk("rst_wlast", WLAST, 1'b0);
    chk("rst_err", usr_cmd_err, 1'b0);
    chk("rst_bvalid", usr_bvalid, 1'b0);
    chk("rst_awaddr", AWADDR, 32'h0);
    chk("rst_bready", BREADY, 1'b1);
    chk("rst_cmd_ready", usr_cmd_ready, 1'b1);
    chk("rst_usr_wready", usr_wready, 1'b0);
    nxt();

    AWREADY = 1'b1; WREADY = 1'b1;
    usr_wvalid = 1'b1;
    issue(8'd5, 32'h1000, 8'd3, 3'd4, 2'd1);
    for (int i = 0; i < 4; i++) begin
      usr_wdata = 128'(i + 32'hA0);
      @(negedge clk);
      if (i == 0) begin
        chk("t1_awvalid", AWVALID, 1'b1);
        chk("t1_awaddr", AWADDR, 32'h1000);
        chk("t1_awlen", AWLEN, 8'd3);
        chk("t1_awid", AWID, 8'd5);
      end
      chk("t1_wvalid", WVALID, 1'b1);
      chk("t1_wlast", WLAST, (i == 3));
      chk("t1_wdata", WDATA, 128'(i + 32'hA0));
      nxt();
    end
    @(negedge clk);
    chk("t1_idle_ready", usr_cmd_ready, 1'b1);
    chk("t1_idle_wvalid", WVALID, 1'b0);
    chk("t1_idle_wready", usr_wready, 1'b0);
    chk("t1_idle_awvalid", AWVALID, 1'b0);
    usr_wvalid = 1'b0;
    nxt();
    send_b(8'd5, 2'd0);

    AWREADY = 1'b0; usr_wvalid = 1'b1;
    issue(8'd1, 32'h2000, 8'd1, 3'd4, 2'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t2_wvalid", WVALID, 1'b1);
      chk("t2_wlast", WLAST, (i == 1));
      nxt();
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_wait_wready", usr_wready, 1'b0);
      chk("t2_wait_wvalid", WVALID, 1'b0);
      chk("t2_wait_awvalid", AWVALID, 1'b1);
      chk("t2_wait_ready", usr_cmd_ready, 1'b0);
      nxt();
    end
    AWREADY = 1'b1;
    @(negedge clk);
    chk("t2_aw_hs_ready", usr_cmd_ready, 1'b0);
    nxt();
    @(negedge clk);
    chk("t2_idle_ready", usr_cmd_ready, 1'b1);
    chk("t2_idle_awvalid", AWVALID, 1'b0);
    usr_wvalid = 1'b0;
    nxt();
    send_b(8'd1, 2'd2);

    issue(8'd2, 32'h0FF0, 8'd1, 3'd4, 2'd1);
    chk_err();
    issue(8'd3, 32'h3000, 8'd2, 3'd4, 2'd2);
    chk_err();
    issue(8'd3, 32'h3000, 8'd0, 3'd5, 2'd1);
    chk_err();
    issue(8'd3, 32'h3000, 8'd0, 3'd4, 2'd3);
    chk_err();
    chk("t3_ost_zero", dut.ost_cnt_q, 3'd0);
    AWREADY = 1'b1; usr_wvalid = 1'b1;
    issue(8'd4, 32'h0FF0, 8'd15, 3'd4, 2'd0);
    @(negedge clk);
    chk("t3_fixed_noerr", usr_cmd_err, 1'b0);
    chk("t3_fixed_awvalid", AWVALID, 1'b1);
    chk("t3_fixed_awburst", AWBURST, 2'd0);
    chk("t3_fixed_awaddr", AWADDR, 32'h0FF0);
    nxt();
    wait_idle();
    send_b(8'd4, 2'd0);
    issue(8'd6, 32'h1FE0, 8'd1, 3'd4, 2'd1);
    @(negedge clk);
    chk("t3_edge_noerr", usr_cmd_err, 1'b0);
    chk("t3_edge_awvalid", AWVALID, 1'b1);
    nxt();
    wait_idle();
    send_b(8'd6, 2'd0);

    for (int k = 0; k < 4; k++) begin
      issue(8'(k), 32'h4000 + 32'(k * 16),
            8'd0, 3'd4, 2'd1);
      @(negedge clk);
      chk("t4_single_wlast", WLAST, 1'b1);
      nxt();
    end
    @(negedge clk);
    chk("t4_full_ready", usr_cmd_ready, 1'b0);
    chk("t4_full_cnt", dut.ost_cnt_q, 3'd4);
    nxt();
    BVALID = 1'b1; BID = 8'd9; BRESP = 2'd0;
    @(negedge clk);
    chk("t4_b_same_ready", usr_cmd_ready, 1'b0);
    nxt();
    BVALID = 1'b0;
    @(negedge clk);
    chk("t4_ready_again", usr_cmd_ready, 1'b1);
    chk("t4_bpulse", usr_bvalid, 1'b1);
    nxt();
    usr_cmd_valid = 1'b1;
    usr_cmd_addr = 32'h4100;
    usr_cmd_len = 8'd0;
    usr_cmd_burst = 2'd1;
    BVALID = 1'b1;
    @(negedge clk);
    chk("t4_simul_ready", usr_cmd_ready, 1'b1);
    nxt();
    usr_cmd_valid = 1'b0; BVALID = 1'b0;
    @(negedge clk);
    chk("t4_simul_beat", WVALID, 1'b1);
    nxt();
    @(negedge clk);
    chk("t4_simul_cnt", dut.ost_cnt_q, 3'd3);
    chk("t4_simul_ready2", usr_cmd_ready, 1'b1);
    nxt();
    for (int k = 0; k < 3; k++) send_b(8'(k), 2'd0);
    chk("t4_drained", dut.ost_cnt_q, 3'd0);
    send_b(8'h33, 2'd3);
    chk("t4_underflow", dut.ost_cnt_q, 3'd0);

    usr_wvalid = 1'b0;
    issue(8'd7, 32'h5000, 8'd255, 3'd0, 2'd1);
    cnt = 0;
    cyc = 0;
    while (cnt < 256 && cyc < 3000) begin
      usr_wvalid = ($urandom_range(0, 3) != 0);
      WREADY     = ($urandom_range(0, 3) != 0);
      usr_wdata  = 128'(cnt);
      @(negedge clk);
      if (WVALID !== usr_wvalid)
        chk("t5_wvalid", WVALID, usr_wvalid);
      if (usr_wvalid && WREADY) begin
        chk("t5_wdata", WDATA, 128'(cnt));
        chk("t5_wlast", WLAST, (cnt == 255));
        cnt++;
      end else if (WLAST && cnt != 255) begin
        chk("t5_wlast_early", WLAST, 1'b0);
      end
      nxt();
      cyc++;
    end
    chk("t5_beats", cnt, 256);
    usr_wvalid = 1'b1; WREADY = 1'b1;
    @(negedge clk);
    chk("t5_post_wvalid", WVALID, 1'b0);
    chk("t5_post_ready", usr_cmd_ready, 1'b1);
    nxt();
    send_b(8'd7, 2'd0);

    AWREADY = 1'b0;
    issue(8'd8, 32'h6000, 8'd7, 3'd4, 2'd1);
    repeat (2) nxt();
    @(negedge clk);
    chk("t6_beat2", WVALID, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_awvalid", AWVALID, 1'b0);
    chk("t6_wvalid", WVALID, 1'b0);
    chk("t6_wlast", WLAST, 1'b0);
    chk("t6_awaddr", AWADDR, 32'h0);
    chk("t6_awlen", AWLEN, 8'h0);
    chk("t6_wready", usr_wready, 1'b0);
    chk("t6_ready", usr_cmd_ready, 1'b1);
    chk("t6_bid", usr_bid, 8'h0);
    chk("t6_bready", BREADY, 1'b1);
    nxt();
    rst_n = 1'b1; AWREADY = 1'b1;
    @(negedge clk);
    chk("t6_post_wvalid", WVALID, 1'b0);
    nxt();
    issue(8'd9, 32'h7000, 8'd0, 3'd4, 2'd1);
    @(negedge clk);
    chk("t6_new_awvalid", AWVALID, 1'b1);
    chk("t6_new_awaddr", AWADDR, 32'h7000);
    chk("t6_new_wlast", WLAST, 1'b1);
    nxt();
    @(negedge clk);
    chk("t6_new_idle", usr_cmd_ready, 1'b1);
    nxt();
    send_b(8'd9, 2'd1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
